// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM command arbiter.
//   arb_state_t  - arbiter FSM state encoding
//   id_width()   - width of a requester index, never below 1 bit
//   field_slice()- extracts field k of width w from a packed per-requester bus
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Upper bounds for the packed-bus helper; callers cast to and from these.
  localparam int unsigned FIELD_BUS_W = 2048;
  localparam int unsigned FIELD_MAX_W = 64;

  function automatic int id_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [FIELD_MAX_W-1:0] field_slice(
    input logic [FIELD_BUS_W-1:0] bus,
    input int unsigned            k,
    input int unsigned            w
  );
    logic [FIELD_BUS_W-1:0] sh;
    sh = bus >> (k * w);
    return sh[FIELD_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sdram_cmd_arbiter_rr_pick.sv
// Rotating-priority picker.
//   req   - request vector, one bit per requester
//   ptr   - index searched first; search continues ptr+1, ... modulo N
//   win   - index of the first requesting bit found
//   valid - at least one request present
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int PTR_W = id_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] win,
  output logic             valid
);

  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_n;
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    idx_n = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx   = (32'(ptr) + i) % N;
      idx_n = PTR_W'(idx);
      if (!valid && req[idx_n]) begin
        valid = 1'b1;
        win   = idx_n;
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port among N_REQ
// requesters. One command is outstanding at a time; the port stays locked
// until i_done (or the watchdog fires) so the data path can steer by o_id.
//   CLK, RST_N          - clock, synchronous active-low reset
//   i_stb/i_ack         - per-requester command handshake (i_ack combinational)
//   i_we/i_addr/i_len   - packed per-requester command descriptors
//   o_stb/o_ack         - command handshake towards the controller
//   o_we/o_addr/o_len   - granted command, held in IDLE
//   o_id                - granted requester index
//   i_done              - controller pulse: burst finished
//   busy                - state != IDLE (registered)
//   err_timeout         - one-cycle pulse on watchdog abort
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int ADDR_W  = 24,
  parameter  int LEN_W   = 4,
  parameter  int TIMEOUT = 1024,
  localparam int ID_W    = id_width(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        i_stb,
  output logic [N_REQ-1:0]        i_ack,
  input  logic [N_REQ-1:0]        i_we,
  input  logic [N_REQ*ADDR_W-1:0] i_addr,
  input  logic [N_REQ*LEN_W-1:0]  i_len,
  output logic                    o_stb,
  input  logic                    o_ack,
  output logic                    o_we,
  output logic [ADDR_W-1:0]       o_addr,
  output logic [LEN_W-1:0]        o_len,
  output logic [ID_W-1:0]         o_id,
  input  logic                    i_done,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int TMR_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [TMR_W-1:0] timer;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (i_stb),
    .ptr   (rr_ptr),
    .win   (pick_id),
    .valid (pick_valid)
  );

  always_comb begin
    i_ack = '0;
    if (RST_N && state == ST_IDLE && pick_valid)
      i_ack[pick_id] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      timer       <= '0;
      o_stb       <= 1'b0;
      o_we        <= 1'b0;
      o_addr      <= '0;
      o_len       <= '0;
      o_id        <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            o_we   <= i_we[pick_id];
            o_addr <= ADDR_W'(field_slice(FIELD_BUS_W'(i_addr), 32'(pick_id), ADDR_W));
            o_len  <= LEN_W'(field_slice(FIELD_BUS_W'(i_len), 32'(pick_id), LEN_W));
            o_id   <= pick_id;
            rr_ptr <= (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);
            o_stb  <= 1'b1;
            busy   <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (o_ack) begin
            o_stb <= 1'b0;
            timer <= '0;
            // Completion can arrive together with the accept for short bursts.
            if (i_done) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (timer != '1)
            timer <= timer + TMR_W'(1);
          // i_done takes priority over a coinciding watchdog expiry.
          if (i_done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (TIMEOUT != 0 && timer == TMR_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          o_stb <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter (N_REQ=4, TIMEOUT=16).
module tb_sdram_cmd_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  i_stb, i_ack, i_we;
  logic [95:0] i_addr;
  logic [15:0] i_len;
  logic        o_stb, o_ack, o_we;
  logic [23:0] o_addr;
  logic [3:0]  o_len;
  logic [1:0]  o_id;
  logic        i_done, busy, err_timeout;

  typedef struct packed {
    logic [1:0]  id;
    logic        we;
    logic [23:0] addr;
    logic [3:0]  len;
  } cmd_t;

  cmd_t cmd_q[$];
  int   ack_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [23:0] addr_v [4] = '{24'h000ABC, 24'h000100, 24'hFFFFFF, 24'h123456};
  logic        we_v   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0]  len_v  [4] = '{4'd1, 4'd8, 4'd15, 4'd0};

  sdram_cmd_arbiter #(.N_REQ(4), .ADDR_W(24), .LEN_W(4), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .i_stb(i_stb), .i_ack(i_ack), .i_we(i_we),
    .i_addr(i_addr), .i_len(i_len), .o_stb(o_stb), .o_ack(o_ack), .o_we(o_we),
    .o_addr(o_addr), .o_len(o_len), .o_id(o_id), .i_done(i_done), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic cmd_t exp_cmd(input int id);
    return {2'(id), we_v[id], addr_v[id], len_v[id]};
  endfunction

  // Monitor: every requester ack and every controller-side transfer is
  // matched against the queued expectation.
  always @(negedge CLK) begin
    if (i_ack !== 4'b0000) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 64'(i_ack), 64'd0);
      end else begin
        int id;
        id = ack_q.pop_front();
        check("i_ack", 64'(i_ack), 64'(4'b0001 << id));
      end
    end
    if (o_stb === 1'b1 && o_ack === 1'b1) begin
      if (cmd_q.size() == 0) begin
        check("unexpected_cmd", 64'(o_id), 64'hFF);
      end else begin
        cmd_t e;
        e = cmd_q.pop_front();
        check("cmd_fields", 64'({o_id, o_we, o_addr, o_len}), 64'(e));
      end
    end
  end

  // done_delay < 0: i_done together with o_ack; otherwise that many WAIT
  // cycles precede the i_done cycle.
  task automatic do_cmd(input logic [3:0] stb, input logic [3:0] stb_after,
                        input int id, input int ack_delay, input int done_delay);
    cmd_t e;
    e = exp_cmd(id);
    ack_q.push_back(id);
    cmd_q.push_back(e);
    i_stb = stb;
    tick;
    i_stb = stb_after;
    check("issue_o_stb", 64'(o_stb), 64'd1);
    check("issue_o_id", 64'(o_id), 64'(id));
    for (int c = 0; c < ack_delay; c++) begin
      check("stall_fields", 64'({o_stb, o_id, o_we, o_addr, o_len}), 64'({1'b1, e}));
      check("stall_no_ack", 64'(i_ack), 64'd0);
      tick;
    end
    o_ack  = 1'b1;
    i_done = (done_delay < 0);
    tick;
    o_ack  = 1'b0;
    i_done = 1'b0;
    if (done_delay >= 0) begin
      check("wait_o_stb", 64'(o_stb), 64'd0);
      check("wait_busy", 64'(busy), 64'd1);
      repeat (done_delay) tick;
      i_done = 1'b1;
      tick;
      i_done = 1'b0;
    end
    check("done_busy", 64'(busy), 64'd0);
    check("done_no_err", 64'(err_timeout), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    RST_N  = 1'b0;
    i_stb  = 4'b1111;
    o_ack  = 1'b0;
    i_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_we[k]         = we_v[k];
      i_addr[k*24 +: 24] = addr_v[k];
      i_len[k*4 +: 4] = len_v[k];
    end
    tick;
    tick;
    check("reset_outputs", 64'({o_stb, o_we, o_addr, o_len, o_id, busy, err_timeout}), 64'd0);
    check("reset_no_ack", 64'(i_ack), 64'd0);
    i_stb = 4'b0000;
    RST_N = 1'b1;
    tick;

    // Single request from 1; done two WAIT cycles in. rr_ptr -> 2.
    do_cmd(4'b0010, 4'b0000, 1, 0, 1);
    check("t1_o_addr", 64'(o_addr), 64'h000100);
    check("t1_o_len", 64'(o_len), 64'd8);
    // rr_ptr=2 with 0 and 2 requesting picks 2; then wrap from 3 to 0.
    do_cmd(4'b0101, 4'b0000, 2, 0, 0);
    do_cmd(4'b0001, 4'b0000, 0, 0, 0);
    do_cmd(4'b1000, 4'b0000, 3, 0, -1);

    // All requesting, immediate accept+done: order 0,1,2,3,0.
    do_cmd(4'b1111, 4'b1111, 0, 0, -1);
    do_cmd(4'b1111, 4'b1111, 1, 0, -1);
    do_cmd(4'b1111, 4'b1111, 2, 0, -1);
    do_cmd(4'b1111, 4'b1111, 3, 0, -1);
    do_cmd(4'b1111, 4'b0000, 0, 0, -1);

    // Watchdog: no i_done, error pulse 16 cycles after the accept edge.
    ack_q.push_back(2);
    cmd_q.push_back(exp_cmd(2));
    i_stb = 4'b0100;
    tick;
    i_stb = 4'b0000;
    o_ack = 1'b1;
    tick;
    o_ack = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check("wd_quiet", 64'({busy, err_timeout}), 64'b10);
      tick;
    end
    check("wd_fire", 64'({busy, err_timeout}), 64'b01);
    tick;
    check("wd_pulse_end", 64'({busy, err_timeout}), 64'b00);

    // Normal grant after abort, then i_done coinciding with expiry.
    do_cmd(4'b0010, 4'b0000, 1, 0, 2);
    do_cmd(4'b0001, 4'b0000, 0, 0, 15);
    tick;
    check("wd_done_wins", 64'(err_timeout), 64'd0);

    // Controller stalls 5 cycles while requester 3 waits; accept with done.
    do_cmd(4'b0100, 4'b1000, 2, 5, -1);

    // Requester 3 granted, then reset mid-WAIT with requester 2 pending.
    ack_q.push_back(3);
    cmd_q.push_back(exp_cmd(3));
    tick;
    i_stb = 4'b0000;
    o_ack = 1'b1;
    tick;
    o_ack = 1'b0;
    tick;
    RST_N = 1'b0;
    i_stb = 4'b0100;
    tick;
    check("midrst_outputs", 64'({o_stb, o_we, o_addr, o_len, o_id, busy, err_timeout}), 64'd0);
    check("midrst_no_ack", 64'(i_ack), 64'd0);
    RST_N = 1'b1;
    do_cmd(4'b0100, 4'b0000, 2, 0, -1);

    tick;
    check("ack_q_empty", 64'(ack_q.size()), 64'd0);
    check("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
